// File: rtl/and_gate_pkg.sv
// Shared limits and sizing helpers for the and_gate datapath primitive.
package and_gate_pkg;

  localparam int AND_GATE_MAX_WIDTH  = 64;
  localparam int AND_GATE_MAX_STAGES = 4;

  // Bits needed to hold a count of 0..w set bits, never narrower than one bit.
  function automatic int count_width(input int w);
    int cw;
    cw = $clog2(w + 1);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/and_gate_pipe_stage.sv
// One registered stage of the and_gate result path: data plus valid bit.
// The data register loads only on a valid beat, so bubbles keep the last valid result.
module and_gate_pipe_stage
  import and_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] d_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    data_d  = data_q;
    valid_d = valid_in;
    if (valid_in) begin
      data_d = d_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the reset branch clears both data and valid so no stale result survives a reset.
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign d_out     = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/and_gate.sv
// Bitwise two-input AND with a combinational result and a PIPE_STAGES-deep registered,
// valid-qualified result plus reduction flags. Define AND_GATE_PARITY_EN to enable parityOut.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic                            clkIn,
  input  logic                            rstIn,
  input  logic [WIDTH-1:0]                aIn,
  input  logic [WIDTH-1:0]                bIn,
  input  logic                            validIn,
  output logic [WIDTH-1:0]                yOut,
  output logic [WIDTH-1:0]                yRegOut,
  output logic                            validOut,
  output logic                            allOut,
  output logic                            anyOut,
  output logic [count_width(WIDTH)-1:0]   onesOut,
  output logic                            parityOut
);

  localparam int CW = count_width(WIDTH);

  if (WIDTH < 1 || WIDTH > AND_GATE_MAX_WIDTH) begin : g_bad_width
    $error("and_gate: WIDTH=%0d outside 1..%0d", WIDTH, AND_GATE_MAX_WIDTH);
  end
  if (PIPE_STAGES < 0 || PIPE_STAGES > AND_GATE_MAX_STAGES) begin : g_bad_stages
    $error("and_gate: PIPE_STAGES=%0d outside 0..%0d", PIPE_STAGES, AND_GATE_MAX_STAGES);
  end

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] final_data;
  logic             final_valid;

  assign y_comb = aIn & bIn;
  assign yOut   = y_comb;

  if (PIPE_STAGES == 0) begin : g_comb
    assign final_data  = y_comb;
    assign final_valid = validIn;
  end else begin : g_pipe
    // Index 0 is the combinational input; index s+1 is the output of stage s.
    logic [PIPE_STAGES:0][WIDTH-1:0] stage_data;
    logic [PIPE_STAGES:0]            stage_valid;

    assign stage_data[0]  = y_comb;
    assign stage_valid[0] = validIn;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      and_gate_pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clkIn),
        .rst      (rstIn),
        .d_in     (stage_data[s]),
        .valid_in (stage_valid[s]),
        .d_out    (stage_data[s+1]),
        .valid_out(stage_valid[s+1])
      );
    end

    assign final_data  = stage_data[PIPE_STAGES];
    assign final_valid = stage_valid[PIPE_STAGES];
  end

  // Flags derive from the final data register, so they line up with yRegOut.
  assign yRegOut  = final_data;
  assign validOut = final_valid;
  assign allOut   = &final_data;
  assign anyOut   = |final_data;
  assign onesOut  = popcount(final_data);

`ifdef AND_GATE_PARITY_EN
  assign parityOut = ^final_data;
`else
  assign parityOut = 1'b0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: a WIDTH=1 combinational instance plus WIDTH=8 instances
// at one, two and three pipeline stages fed identical directed vectors.
module tb_and_gate;

  typedef struct packed {
    logic [7:0] y;
    logic       all;
    logic       any;
    logic [3:0] ones;
    logic       par;
  } exp_t;

  logic clk;
  logic rst;

  logic       a1, b1, v1;
  logic       y1, yr1, vo1, all1, any1, par1;
  logic [0:0] ones1;

  logic [7:0] a8, b8;
  logic       v8;
  logic [7:0] y8   [3];
  logic [7:0] yr8  [3];
  logic       vo8  [3];
  logic       all8 [3];
  logic       any8 [3];
  logic [3:0] ones8[3];
  logic       par8 [3];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  exp_t hist[$];
  int   rd_idx[3] = '{0, 0, 0};
  exp_t last[3]   = '{'0, '0, '0};

  and_gate #(.WIDTH(1), .PIPE_STAGES(0)) u_w1p0 (
    .clkIn(clk), .rstIn(rst), .aIn(a1), .bIn(b1), .validIn(v1),
    .yOut(y1), .yRegOut(yr1), .validOut(vo1), .allOut(all1), .anyOut(any1),
    .onesOut(ones1), .parityOut(par1)
  );

  and_gate #(.WIDTH(8), .PIPE_STAGES(1)) u_w8p1 (
    .clkIn(clk), .rstIn(rst), .aIn(a8), .bIn(b8), .validIn(v8),
    .yOut(y8[0]), .yRegOut(yr8[0]), .validOut(vo8[0]), .allOut(all8[0]), .anyOut(any8[0]),
    .onesOut(ones8[0]), .parityOut(par8[0])
  );

  and_gate #(.WIDTH(8), .PIPE_STAGES(2)) u_w8p2 (
    .clkIn(clk), .rstIn(rst), .aIn(a8), .bIn(b8), .validIn(v8),
    .yOut(y8[1]), .yRegOut(yr8[1]), .validOut(vo8[1]), .allOut(all8[1]), .anyOut(any8[1]),
    .onesOut(ones8[1]), .parityOut(par8[1])
  );

  and_gate #(.WIDTH(8), .PIPE_STAGES(3)) u_w8p3 (
    .clkIn(clk), .rstIn(rst), .aIn(a8), .bIn(b8), .validIn(v8),
    .yOut(y8[2]), .yRegOut(yr8[2]), .validOut(vo8[2]), .allOut(all8[2]), .anyOut(any8[2]),
    .onesOut(ones8[2]), .parityOut(par8[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Parity expectations collapse to 0 when the parity feature is compiled out.
  function automatic logic par_exp(input logic p);
`ifdef AND_GATE_PARITY_EN
    return p;
`else
    return 1'b0 & p;
`endif
  endfunction

  function automatic exp_t mk(input logic [7:0] y, input logic all, input logic any,
                              input logic [3:0] ones, input logic par);
    exp_t e;
    e.y    = y;
    e.all  = all;
    e.any  = any;
    e.ones = ones;
    e.par  = par_exp(par);
    return e;
  endfunction

  task automatic cmp_stage(input string tag, input int i, input exp_t e);
    check({tag, "_yRegOut"},   i, 64'(yr8[i]),   64'(e.y));
    check({tag, "_allOut"},    i, 64'(all8[i]),  64'(e.all));
    check({tag, "_anyOut"},    i, 64'(any8[i]),  64'(e.any));
    check({tag, "_onesOut"},   i, 64'(ones8[i]), 64'(e.ones));
    check({tag, "_parityOut"}, i, 64'(par8[i]),  64'(e.par));
  endtask

  // Drive one beat just after the edge; valid beats push their expectation into the scoreboard.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v, input exp_t e);
    @(posedge clk);
    #1;
    a8 = a;
    b8 = b;
    v8 = v;
    if (v) hist.push_back(e);
    #1;
    for (int k = 0; k < 3; k++) check("yOut", k, 64'(y8[k]), 64'(e.y));
  endtask

  // Monitor: pops on validOut, otherwise checks that the last delivered result is held.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (vo8[i]) begin
          check("has_expected", i, 64'(hist.size() > rd_idx[i]), 64'd1);
          if (hist.size() > rd_idx[i]) begin
            last[i] = hist[rd_idx[i]];
            rd_idx[i]++;
            cmp_stage("valid", i, last[i]);
          end
        end else begin
          cmp_stage("hold", i, last[i]);
        end
      end
    end
  end

  initial begin
    logic [3:0] and_tab;
    logic [1:0] ab;
    and_tab = 4'b1000;
    rst = 1'b1;
    a8 = '0; b8 = '0; v8 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    #1;

    // Combinational instance, exercised while reset is asserted (it must ignore reset).
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      v1 = ~v1;
      #1;
      check("w1_yOut",      i, 64'(y1),    64'(and_tab[i]));
      check("w1_yRegOut",   i, 64'(yr1),   64'(and_tab[i]));
      check("w1_validOut",  i, 64'(vo1),   64'(v1));
      check("w1_allOut",    i, 64'(all1),  64'(and_tab[i]));
      check("w1_anyOut",    i, 64'(any1),  64'(and_tab[i]));
      check("w1_onesOut",   i, 64'(ones1), 64'(and_tab[i]));
      check("w1_parityOut", i, 64'(par1),  64'(par_exp(and_tab[i])));
      #4;
    end
    a1 = 1'b0;
    b1 = 1'bx;
    #1;
    check("w1_zero_and_x", 0, 64'(y1), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    drive8(8'hF0, 8'h3C, 1'b1, mk(8'h30, 1'b0, 1'b1, 4'd2, 1'b0));
    drive8(8'hFF, 8'hFF, 1'b1, mk(8'hFF, 1'b1, 1'b1, 4'd8, 1'b0));
    drive8(8'h00, 8'hFF, 1'b0, mk(8'h00, 1'b0, 1'b0, 4'd0, 1'b0));
    drive8(8'h00, 8'hFF, 1'b0, mk(8'h00, 1'b0, 1'b0, 4'd0, 1'b0));
    drive8(8'h07, 8'hFF, 1'b1, mk(8'h07, 1'b0, 1'b1, 4'd3, 1'b1));
    drive8(8'hAA, 8'h0F, 1'b1, mk(8'h0A, 1'b0, 1'b1, 4'd2, 1'b0));
    drive8(8'h01, 8'hFF, 1'b1, mk(8'h01, 1'b0, 1'b1, 4'd1, 1'b1));
    drive8(8'h3C, 8'hC3, 1'b1, mk(8'h00, 1'b0, 1'b0, 4'd0, 1'b0));
    drive8(8'hF0, 8'hFF, 1'b1, mk(8'hF0, 1'b0, 1'b1, 4'd4, 1'b0));
    drive8(8'h0F, 8'hFF, 1'b1, mk(8'h0F, 1'b0, 1'b1, 4'd4, 1'b0));
    drive8(8'hFF, 8'h81, 1'b1, mk(8'h81, 1'b0, 1'b1, 4'd2, 1'b0));

    // Reset with operands in flight and validIn high; nothing from before or during it may emerge.
    @(posedge clk);
    #1;
    rst = 1'b1;
    a8  = 8'hFF;
    b8  = 8'hFF;
    v8  = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check("yOut_in_reset", k, 64'(y8[k]), 64'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v8  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_idx[k] = hist.size();
      last[k]   = '0;
    end
    repeat (4) @(posedge clk);

    drive8(8'hC0, 8'hFF, 1'b1, mk(8'hC0, 1'b0, 1'b1, 4'd2, 1'b0));
    drive8(8'h00, 8'h00, 1'b0, mk(8'h00, 1'b0, 1'b0, 4'd0, 1'b0));
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("drained", k, 64'(rd_idx[k]), 64'(hist.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
